vga_pixel_pipeline: RTL and testbench

- Downstream consumer of the 640x480@60 pixel cursor. Takes its raw hcount/vcount/active/hsync/vsync and fetches pixels from a 160x120 double-buffered framebuffer with 4x pixel replication.
- Emits registered 4:4:4 RGB and negative-polarity VGA syncs, delayed so colour and sync stay aligned.
- Provides frame-boundary bank swapping for the renderer that writes the framebuffer.

---
 rtl/vga_pixel_pipeline_if.sv | 35 +++
 rtl/vga_pixel_pipeline.sv | 152 +++++++++++++++
 tb/tb_vga_pixel_pipeline.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_pipeline_if.sv
// ---------------------------------------------------------------------------
// vga_pixel_pipeline_if
//   Framebuffer read port between the VGA pixel pipeline (master) and the
//   double-buffered framebuffer memory (slave).
//
//   fb_rd_en  master->slave  read strobe
//   fb_addr   master->slave  read address, ADDR_W bits
//   fb_bank   master->slave  bank currently being displayed
//   fb_rdata  slave->master  {r[3:0],g[3:0],b[3:0]}, valid a fixed number
//                            of cycles after fb_rd_en/fb_addr
// ---------------------------------------------------------------------------
interface vga_pixel_pipeline_if #(
  parameter int ADDR_W = 15
);

  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_bank;
  logic [11:0]       fb_rdata;

  modport master (
    output fb_rd_en,
    output fb_addr,
    output fb_bank,
    input  fb_rdata
  );

  modport slave (
    input  fb_rd_en,
    input  fb_addr,
    input  fb_bank,
    output fb_rdata
  );

endinterface

// File: rtl/vga_pixel_pipeline.sv
// ---------------------------------------------------------------------------
// vga_pixel_pipeline
//   Consumes the raw 640x480@60 pixel cursor, fetches pixels from a 160x120
//   double-buffered framebuffer with 4x replication in both axes, and drives
//   registered 4:4:4 RGB plus negative-polarity syncs. Colour and syncs share
//   the same RD_LAT+2 cycle latency. Also swaps the displayed bank at the
//   start of vertical blanking on request from the renderer.
//
//   pix_clk      pixel clock, all logic on its rising edge
//   reset        synchronous, active-high
//   hcount       cursor x, 0..799
//   vcount       cursor y, 0..524
//   active       cursor visible-region flag
//   hsync/vsync  cursor syncs, active-high
//   swap_req     one-cycle request to swap banks at the next vblank
//   fb           framebuffer read port (master side)
//   vga_r/g/b    registered colour, forced to 0 while blanking
//   vga_hsync    active-low hsync, aligned with colour
//   vga_vsync    active-low vsync, aligned with colour
//   frame_start  one-cycle pulse after the cursor sits at (0,0)
//   swap_done    one-cycle pulse in the cycle fb_bank changes
// ---------------------------------------------------------------------------
module vga_pixel_pipeline #(
  parameter int RD_LAT = 2,
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15
) (
  input  logic                 pix_clk,
  input  logic                 reset,
  input  logic [9:0]           hcount,
  input  logic [9:0]           vcount,
  input  logic                 active,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic                 swap_req,
  vga_pixel_pipeline_if.master fb,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 frame_start,
  output logic                 swap_done
);

  // The row stride is hard-wired as (y<<7)+(y<<5), so only a 160-wide
  // framebuffer is supported; the delay line assumes a 1..4 cycle memory.
  if (RD_LAT < 1 || RD_LAT > 4 || FB_W != 160 ||
      FB_W * FB_H > (1 << ADDR_W)) begin : g_bad_params
    $error("vga_pixel_pipeline: unsupported RD_LAT/FB_W/FB_H/ADDR_W");
  end

  // -------------------------------------------------------------------------
  // Stage A: address generation
  // -------------------------------------------------------------------------
  logic [7:0]        x;
  logic [7:0]        y;
  logic [ADDR_W-1:0] addr_next;

  assign x = hcount[9:2];
  assign y = vcount[9:2];

  // y*160 + x without a multiplier; arithmetic wraps at ADDR_W.
  assign addr_next = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      fb.fb_rd_en <= 1'b0;
      fb.fb_addr  <= '0;
    end else begin
      fb.fb_rd_en <= active;
      fb.fb_addr  <= active ? addr_next : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Control delay line: RD_LAT+1 stages here, the output register below is
  // the final stage, so control and colour leave together.
  // -------------------------------------------------------------------------
  logic [RD_LAT:0] act_dly;
  logic [RD_LAT:0] hs_dly;
  logic [RD_LAT:0] vs_dly;

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      act_dly <= '0;
      hs_dly  <= '0;
      vs_dly  <= '0;
    end else begin
      // NOTE: non-blocking assignment makes every stage capture its
      // neighbour's pre-edge value, so this is a true shift register.
      act_dly <= {act_dly[RD_LAT-1:0], active};
      hs_dly  <= {hs_dly[RD_LAT-1:0],  hsync};
      vs_dly  <= {vs_dly[RD_LAT-1:0],  vsync};
    end
  end

  // -------------------------------------------------------------------------
  // Stage B: colour capture with blanking, sync inversion
  // -------------------------------------------------------------------------
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hsync             <= 1'b1;
      vga_vsync             <= 1'b1;
    end else begin
      {vga_r, vga_g, vga_b} <= act_dly[RD_LAT] ? fb.fb_rdata : 12'h000;
      vga_hsync             <= ~hs_dly[RD_LAT];
      vga_vsync             <= ~vs_dly[RD_LAT];
    end
  end

  // -------------------------------------------------------------------------
  // Frame start marker
  // -------------------------------------------------------------------------
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= (hcount == 10'd0) && (vcount == 10'd0);
    end
  end

  // -------------------------------------------------------------------------
  // Bank swap. The swap point is the first pixel of the first blanking line,
  // so no visible pixel can still be in flight when fb_bank changes.
  // A request landing on the swap point itself is honoured immediately.
  // -------------------------------------------------------------------------
  logic swap_point;
  logic pending;

  assign swap_point = (hcount == 10'd0) && (vcount == 10'd480);

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      fb.fb_bank <= 1'b0;
      swap_done  <= 1'b0;
      pending    <= 1'b0;
    end else if (swap_point && (pending || swap_req)) begin
      fb.fb_bank <= ~fb.fb_bank;
      swap_done  <= 1'b1;
      pending    <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      if (swap_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_pipeline
//   Directed bench for vga_pixel_pipeline with RD_LAT=2. A small memory model
//   returns addr[11:0]^12'h5A3 two cycles after the address, or 12'hFFF when
//   fff_mode is set. Inputs change 1 time unit after the rising edge; outputs
//   are read at the same point, i.e. they show the state after that edge.
// ---------------------------------------------------------------------------
module tb_vga_pixel_pipeline;

  localparam int RD_LAT = 2;
  localparam int ADDR_W = 15;
  localparam logic [32:0] RST_OUTS = 33'h0_0000_000C;

  logic       pix_clk = 1'b0;
  logic       reset;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       swap_req;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       frame_start;
  logic       swap_done;
  logic [11:0] rgb;

  logic        fff_mode = 1'b0;
  logic [11:0] rd_pipe [RD_LAT];

  int total = 0;
  int bad   = 0;

  vga_pixel_pipeline_if #(.ADDR_W(ADDR_W)) fb ();

  vga_pixel_pipeline #(
    .RD_LAT(RD_LAT), .FB_W(160), .FB_H(120), .ADDR_W(ADDR_W)
  ) dut (
    .pix_clk    (pix_clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .active     (active),
    .hsync      (hsync),
    .vsync      (vsync),
    .swap_req   (swap_req),
    .fb         (fb),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .frame_start(frame_start),
    .swap_done  (swap_done)
  );

  always #5 pix_clk = ~pix_clk;

  assign rgb = {vga_r, vga_g, vga_b};

  // Framebuffer model with RD_LAT cycles of read latency.
  always @(posedge pix_clk) begin
    rd_pipe[0] <= fb.fb_addr[11:0] ^ 12'h5A3;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb.fb_rdata = fff_mode ? 12'hFFF : rd_pipe[RD_LAT-1];

  function automatic logic [32:0] outs();
    return {fb.fb_rd_en, fb.fb_addr, fb.fb_bank, vga_r, vga_g, vga_b,
            vga_hsync, vga_vsync, frame_start, swap_done};
  endfunction

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  // Cursor with hsync on hcount 688..783 and vsync on lines 513..514.
  task automatic set_cursor(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
    active = (h < 640) && (v < 480);
    hsync  = (h >= 688) && (h < 784);
    vsync  = (v >= 513) && (v < 515);
  endtask

  task automatic adv(inout int h, inout int v);
    h++;
    if (h == 800) begin
      h = 0;
      v++;
      if (v == 525) v = 0;
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    swap_req = 1'b0;
    fff_mode = 1'b1;
    set_cursor(20, 20);
    tick();
    tick();
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL reset_values: got=%h exp=%h", outs(), RST_OUTS);
    end
    reset = 1'b0;
    fff_mode = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_first_pixel();
    int          hs [5]   = '{0, 4, 8, 12, 16};
    logic [11:0] exp_rgb [10] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h5A3,
                                  12'h5A2, 12'h5A1, 12'h5A0, 12'h5A7, 12'h000};
    for (int t = 1; t <= 9; t++) begin
      if (t <= 5) set_cursor(hs[t-1], 0);
      else        set_cursor(650, 0);
      tick();
      if (t == 1) begin
        total++;
        if ({fb.fb_rd_en, fb.fb_addr, frame_start} !== {1'b1, 15'd0, 1'b1}) begin
          bad++;
          $display("FAIL first_stage_a: got en=%b addr=%0d fs=%b exp en=1 addr=0 fs=1",
                   fb.fb_rd_en, fb.fb_addr, frame_start);
        end
      end
      if (t == 2) begin
        total++;
        if (frame_start !== 1'b0) begin
          bad++;
          $display("FAIL frame_start_single: got=%b exp=0", frame_start);
        end
      end
      if (t >= 3) begin
        total++;
        if (rgb !== exp_rgb[t]) begin
          bad++;
          $display("FAIL first_pixel_rgb t=%0d: got=%h exp=%h", t, rgb, exp_rgb[t]);
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_addr_map();
    // {hcount, vcount, expected addr, expected rd_en}
    int vec [9][4] = '{
      '{7,   5,   161,   1},  // x=1, y=1
      '{639, 479, 19199, 1},  // x=159, y=119
      '{0,   9,   320,   1},
      '{1,   9,   320,   1},
      '{2,   9,   320,   1},
      '{3,   9,   320,   1},
      '{4,   9,   321,   1},
      '{650, 9,   0,     0},
      '{100, 500, 0,     0}
    };
    for (int i = 0; i < 9; i++) begin
      set_cursor(vec[i][0], vec[i][1]);
      tick();
      total++;
      if ({fb.fb_rd_en, fb.fb_addr} !== {1'(vec[i][3]), 15'(vec[i][2])}) begin
        bad++;
        $display("FAIL addr_map h=%0d v=%0d: got en=%b addr=%0d exp en=%0d addr=%0d",
                 vec[i][0], vec[i][1], fb.fb_rd_en, fb.fb_addr, vec[i][3], vec[i][2]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_hsync_line();
    int h = 0;
    int v = 100;
    int lows = 0;
    int first = -1;
    logic [11:0] exp;
    fff_mode = 1'b1;
    for (int j = 0; j < 808; j++) begin
      set_cursor(h, v);
      tick();
      adv(h, v);
      if (vga_hsync === 1'b0) begin
        lows++;
        if (first < 0) first = j;
      end
      if (j >= 3) begin
        exp = (((j - 3) % 800) < 640) ? 12'hFFF : 12'h000;
        total++;
        if (rgb !== exp) begin
          bad++;
          $display("FAIL blanking_rgb j=%0d: got=%h exp=%h", j, rgb, exp);
        end
      end
    end
    total++;
    if (lows !== 96) begin
      bad++;
      $display("FAIL hsync_width: got=%0d exp=96", lows);
    end
    total++;
    if (first !== 691) begin
      bad++;
      $display("FAIL hsync_start: got=%0d exp=691", first);
    end
    fff_mode = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_vsync();
    int h = 790;
    int v = 512;
    int lows = 0;
    int first = -1;
    int last = -1;
    for (int j = 0; j < 1630; j++) begin
      set_cursor(h, v);
      tick();
      adv(h, v);
      if (vga_vsync === 1'b0) begin
        lows++;
        if (first < 0) first = j;
        last = j;
      end
    end
    total++;
    if (lows !== 1600) begin
      bad++;
      $display("FAIL vsync_width: got=%0d exp=1600", lows);
    end
    total++;
    if (first !== 13 || last !== 1612) begin
      bad++;
      $display("FAIL vsync_window: got=%0d..%0d exp=13..1612", first, last);
    end
  endtask

  // -------------------------------------------------------------------------
  // Runs 30 cycles from (790,479) or (795,479) and checks bank/swap_done
  // against a toggle expected at cycle swap_at (-1 for none).
  task automatic run_vblank(input int start_h, input int req_at, input int swap_at,
                            input logic bank_before, input string name);
    int h = start_h;
    int v = 479;
    logic [1:0] exp;
    for (int j = 0; j < 30; j++) begin
      swap_req = (j == req_at);
      set_cursor(h, v);
      tick();
      adv(h, v);
      if (swap_at >= 0 && j >= swap_at) exp[1] = ~bank_before;
      else                               exp[1] = bank_before;
      exp[0] = (j == swap_at);
      total++;
      if ({fb.fb_bank, swap_done} !== exp) begin
        bad++;
        $display("FAIL %s j=%0d: got bank=%b done=%b exp bank=%b done=%b",
                 name, j, fb.fb_bank, swap_done, exp[1], exp[0]);
      end
    end
    swap_req = 1'b0;
  endtask

  task automatic test_swap_absorb();
    set_cursor(100, 300);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    tick();
    swap_req = 1'b1;
    set_cursor(104, 300);
    tick();
    swap_req = 1'b0;
    tick();
    total++;
    if ({fb.fb_bank, swap_done} !== 2'b00) begin
      bad++;
      $display("FAIL swap_midframe: got bank=%b done=%b exp bank=0 done=0",
               fb.fb_bank, swap_done);
    end
    run_vblank(790, -1, 10, 1'b0, "swap_pending");
    run_vblank(790, -1, -1, 1'b1, "swap_no_repeat");
  endtask

  task automatic test_swap_same_cycle();
    run_vblank(795, 5, 5, 1'b1, "swap_same_cycle");
    run_vblank(795, 6, -1, 1'b0, "swap_late_req");
    run_vblank(795, -1, 5, 1'b0, "swap_deferred");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_frame();
    int h = 290;
    int v = 200;
    fff_mode = 1'b1;
    for (int j = 0; j < 10; j++) begin
      swap_req = (j == 0);
      set_cursor(h, v);
      tick();
      adv(h, v);
    end
    swap_req = 1'b0;
    total++;
    if ({fb.fb_rd_en, fb.fb_bank, rgb} !== {1'b1, 1'b1, 12'hFFF}) begin
      bad++;
      $display("FAIL pre_reset_state: got en=%b bank=%b rgb=%h exp en=1 bank=1 rgb=fff",
               fb.fb_rd_en, fb.fb_bank, rgb);
    end
    reset = 1'b1;
    set_cursor(300, 200);
    tick();
    reset = 1'b0;
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL reset_mid_frame: got=%h exp=%h", outs(), RST_OUTS);
    end
    h = 301;
    for (int j = 0; j < 6; j++) begin
      set_cursor(h, v);
      tick();
      adv(h, v);
      total++;
      if (rgb !== ((j >= 3) ? 12'hFFF : 12'h000)) begin
        bad++;
        $display("FAIL resume_rgb j=%0d: got=%h exp=%h", j, rgb,
                 (j >= 3) ? 12'hFFF : 12'h000);
      end
    end
    fff_mode = 1'b0;
    run_vblank(790, -1, -1, 1'b0, "pending_cleared");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_frame_start();
    int h = 790;
    int v = 524;
    int pulses = 0;
    for (int j = 0; j < 30; j++) begin
      set_cursor(h, v);
      tick();
      adv(h, v);
      if (frame_start === 1'b1) pulses++;
      total++;
      if (frame_start !== (j == 10)) begin
        bad++;
        $display("FAIL frame_start j=%0d: got=%b exp=%b", j, frame_start, (j == 10));
      end
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL frame_start_count: got=%0d exp=1", pulses);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    reset    = 1'b1;
    swap_req = 1'b0;
    set_cursor(650, 0);
    test_reset();
    test_first_pixel();
    test_addr_map();
    test_hsync_line();
    test_vsync();
    test_swap_absorb();
    test_swap_same_cycle();
    test_reset_mid_frame();
    test_frame_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
